gravity_player_array: RTL and testbench
=======================================

# gravity_player_array

Parametrised multi-player gravity engine for the gravity-flip game. It replaces the per-player chain of dead detection, gravity direction and player movement with one block that serves NUM_PLAYERS players, NUM_LANES platform lanes and a lock-in/game-over state machine. It sits between the debounced player buttons and lane-presence bits on one side, and the display/scoring logic on the other. It advances on a tick enable in the system clock domain instead of on a derived clock.

## Interface
- NUM_PLAYERS, 4: number of player channels (1..8).
- NUM_LANES, 3: number of platform lanes (1..8).
- H_WIDTH, 9: height width in bits.
- H_MAX, 479: highest legal height.
- LANE_BASE, 40: height of lane 0's surface.
- LANE_PITCH, 160: spacing between lanes; lane k is at LANE_BASE + k*LANE_PITCH.
- SPEED, 4: height change per tick when airborne (1..LANE_PITCH-1).
- SPAWN_H, 200: start height; must equal a lane height.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-cycle frame enable (60 Hz rate).
- start  in  1  one-cycle pulse, already debounced.
- en  in  NUM_PLAYERS  player-enable switches, sampled on start.
- toggle  in  NUM_PLAYERS  debounced gravity buttons (level).
- lanes  in  NUM_PLAYERS*NUM_LANES  platform present at each player's column; bit [i*NUM_LANES+k] = player i, lane k.
- height  out  NUM_PLAYERS*H_WIDTH  player heights; player i is at [i*H_WIDTH +: H_WIDTH].
- grav_dir  out  NUM_PLAYERS  0 = down (height decreasing), 1 = up.
- alive  out  NUM_PLAYERS  player is in play and not dead.
- enable_board  out  1  high while in PLAY.
- game_over  out  1  high while in OVER.
- winner  out  3  index of the last surviving player.
- winner_valid  out  1  winner is meaningful.

## Operation
- States: IDLE, PLAY, OVER. Reset puts the block in IDLE.
- IDLE:
  - All heights are SPAWN_H, grav_dir is 0, alive is 0, and pending toggles are cleared.
  - start with en != 0: latch en into in_game, set alive = en, capture multi = (popcount(en) >= 2), go to PLAY.
  - start with en == 0: ignored.
- PLAY: enable_board = 1. Players with alive = 0 are frozen; their height and grav_dir hold.
- Toggle capture:
  - The rising edge of toggle[i] (against a registered copy) sets pending[i].
  - An edge in the same cycle as tick counts for that tick.
  - Every tick clears pending, whether or not it was applied.
- Per tick, for each alive player, using its current h and lane bits L:
  - grounded: some k has L[k] = 1 and LANE_Y(k) == h.
  - If grounded and pending: grav_dir flips, and this tick's move uses the new direction. Toggles while airborne are discarded.
  - Down move: candidates are lanes with L[k] = 1 and h-SPEED <= LANE_Y(k) <= h. If any exist, the new h is the largest candidate (landing). Otherwise, if h < SPEED the player dies; otherwise the new h is h-SPEED.
  - Up move: the same rule, mirrored. Candidates lie in h <= LANE_Y(k) <= h+SPEED and the smallest is chosen. With no candidate and h+SPEED > H_MAX, the player dies.
  - Death clears alive[i] and holds height at its pre-tick value.
  - Compute in H_WIDTH+1 bits; there is no wrap-around.
- End of game, evaluated on registered alive:
  - multi: one alive player → OVER, winner = its index, winner_valid = 1. Zero alive (simultaneous death) → OVER, winner_valid = 0.
  - single: zero alive → OVER, winner_valid = 0.
- OVER: game_over = 1, all state is frozen, and start returns the block to IDLE.

## Timing
- Reset values: height = SPAWN_H for all players, grav_dir = 0, alive = 0, enable_board = 0, game_over = 0, winner = 0, winner_valid = 0.
- start → PLAY: enable_board and alive are high the next cycle.
- A tick in cycle n updates height, grav_dir and alive, visible in cycle n+1.
- game_over is high in cycle n+2 after the deciding tick.
- tick while in IDLE or OVER: ignored.
- start while in PLAY: ignored.
- reset mid-game: IDLE on the next edge, overriding tick and start.

## Test plan
- Reset and default parameters: all outputs hold their reset values. Then start with en = 4'b0011 → alive = 0011 and enable_board = 1 one cycle later.
- Free fall: player 0 at 200 with all lanes clear. After 10 ticks, height = 160 and the player is still alive.
- Landing clamp: player 0 at 42, down, lane0 bit = 1, one tick → 40. Further ticks → stays at 40 (grounded).
- Flip gating:
  - Toggle edge while airborne at 160 → grav_dir stays 0.
  - Toggle edge while grounded at 40 → next tick gives grav_dir = 1 and height 44.
- Death: player 0 at 2, down, no lanes, one tick → alive[0] = 0 and height holds at 2. Player 1 is still alive → two cycles later game_over = 1, winner = 1, winner_valid = 1.
- Simultaneous death, single-player mode, and return:
  - Two players die on the same tick → winner_valid = 0.
  - With en = 0001, player 0's death → game_over = 1.
  - start in OVER → IDLE, with heights back to 200.

Source files
------------

// File: rtl/gravity_player_array.sv
// gravity_player_array
// Shared gravity engine for up to eight players: per-player dead detection,
// gravity direction and movement, plus the IDLE/PLAY/OVER game sequencer.
// The engine advances only on the one-cycle frame tick.
module gravity_player_array #(
    parameter int NUM_PLAYERS = 4,
    parameter int NUM_LANES   = 3,
    parameter int H_WIDTH     = 9,
    parameter int H_MAX       = 479,
    parameter int LANE_BASE   = 40,
    parameter int LANE_PITCH  = 160,
    parameter int SPEED       = 4,
    parameter int SPAWN_H     = 200
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tick,
    input  logic                             start,
    input  logic [NUM_PLAYERS-1:0]           en,
    input  logic [NUM_PLAYERS-1:0]           toggle,
    input  logic [NUM_PLAYERS*NUM_LANES-1:0] lanes,
    output logic [NUM_PLAYERS*H_WIDTH-1:0]   height,
    output logic [NUM_PLAYERS-1:0]           grav_dir,
    output logic [NUM_PLAYERS-1:0]           alive,
    output logic                             enable_board,
    output logic                             game_over,
    output logic [2:0]                       winner,
    output logic                             winner_valid
);

    // Geometry constants widened to 32 bits so that h+SPEED and the lane
    // heights of high lane indices can never wrap.
    localparam logic [31:0]        LANE_Y0 = 32'(LANE_BASE);
    localparam logic [31:0]        LANE_DY = 32'(LANE_PITCH);
    localparam logic [31:0]        STEP    = 32'(SPEED);
    localparam logic [31:0]        TOP     = 32'(H_MAX);
    localparam logic [H_WIDTH-1:0] SPAWN_V = H_WIDTH'(SPAWN_H);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t                              r_state;
    state_t                              w_next_state;

    logic [NUM_PLAYERS-1:0][H_WIDTH-1:0] r_height;
    logic [NUM_PLAYERS-1:0][H_WIDTH-1:0] w_height_step;
    logic [NUM_PLAYERS-1:0]              r_grav;
    logic [NUM_PLAYERS-1:0]              w_grav_step;
    logic [NUM_PLAYERS-1:0]              r_alive;
    logic [NUM_PLAYERS-1:0]              w_alive_step;
    logic [NUM_PLAYERS-1:0]              r_pend;
    logic [NUM_PLAYERS-1:0]              w_pend_eff;
    logic [NUM_PLAYERS-1:0]              r_tog_q;
    logic                                r_multi;
    logic                                r_enable_board;
    logic                                r_game_over;
    logic [2:0]                          r_winner;
    logic                                r_winner_valid;
    logic [3:0]                          w_alive_cnt;
    logic [2:0]                          w_alive_idx;
    logic                                w_start_ok;
    logic                                w_sole_survivor;

    // Number of set bits in a player vector (at most eight players).
    function automatic logic [3:0] f_popcount(input logic [NUM_PLAYERS-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

    // Index of the highest set bit; only meaningful when exactly one bit is set.
    function automatic logic [2:0] f_last_index(input logic [NUM_PLAYERS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // One frame of motion for one alive player.
    // Returns {survives, new_dir, new_height}.
    // A player that flips this tick pushes off the lane it stands on, so that
    // lane is not a landing candidate for the move that follows the flip.
    function automatic logic [H_WIDTH+1:0] f_step(
        input logic [H_WIDTH-1:0]   h,
        input logic                 dir,
        input logic                 pend,
        input logic [NUM_LANES-1:0] lb
    );
        logic [31:0]        hx;
        logic [31:0]        ly;
        logic [31:0]        best;
        logic               grounded;
        logic               flip;
        logic               d;
        logic               found;
        logic               survives;
        logic [H_WIDTH-1:0] nh;
        hx       = 32'(h);
        grounded = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            ly = LANE_Y0 + LANE_DY * 32'(k);
            if (lb[k] && (ly == hx)) begin
                grounded = 1'b1;
            end
        end
        flip  = grounded & pend;
        d     = dir ^ flip;
        found = 1'b0;
        best  = 32'd0;
        for (int k = 0; k < NUM_LANES; k++) begin
            ly = LANE_Y0 + LANE_DY * 32'(k);
            if (lb[k] && !(flip && (ly == hx))) begin
                if (!d) begin
                    if ((ly <= hx) && (ly + STEP >= hx) && (!found || (ly > best))) begin
                        found = 1'b1;
                        best  = ly;
                    end
                end else begin
                    if ((ly >= hx) && (ly <= hx + STEP) && (!found || (ly < best))) begin
                        found = 1'b1;
                        best  = ly;
                    end
                end
            end
        end
        survives = 1'b1;
        nh       = h;
        if (found) begin
            nh = H_WIDTH'(best);
        end else if (!d) begin
            if (hx < STEP) begin
                survives = 1'b0;
            end else begin
                nh = H_WIDTH'(hx - STEP);
            end
        end else begin
            if (hx + STEP > TOP) begin
                survives = 1'b0;
            end else begin
                nh = H_WIDTH'(hx + STEP);
            end
        end
        return {survives, d, nh};
    endfunction

    // Per-player tick result plus the pending-toggle view including this cycle's edge.
    always_comb begin
        w_pend_eff    = r_pend | (toggle & ~r_tog_q);
        w_height_step = r_height;
        w_grav_step   = r_grav;
        w_alive_step  = r_alive;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (r_alive[i]) begin
                {w_alive_step[i], w_grav_step[i], w_height_step[i]} =
                    f_step(r_height[i], r_grav[i], w_pend_eff[i],
                           lanes[i*NUM_LANES +: NUM_LANES]);
            end else begin
                w_alive_step[i] = 1'b0;
            end
        end
    end

    // Game sequencer next-state; end of game is judged on the registered alive vector.
    always_comb begin
        w_alive_cnt     = f_popcount(r_alive);
        w_alive_idx     = f_last_index(r_alive);
        w_start_ok      = start & (|en);
        w_sole_survivor = r_multi & (w_alive_cnt == 4'd1);
        w_next_state    = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_PLAY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if ((w_alive_cnt == 4'd0) || w_sole_survivor) begin
                    w_next_state = ST_OVER;
                end else begin
                    w_next_state = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_OVER;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered status flags and winner capture on the PLAY -> OVER transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable_board <= 1'b0;
            r_game_over    <= 1'b0;
            r_winner       <= 3'd0;
            r_winner_valid <= 1'b0;
        end else begin
            r_enable_board <= (w_next_state == ST_PLAY);
            r_game_over    <= (w_next_state == ST_OVER);
            if ((r_state == ST_PLAY) && (w_next_state == ST_OVER)) begin
                r_winner_valid <= w_sole_survivor;
                if (w_sole_survivor) begin
                    r_winner <= w_alive_idx;
                end else begin
                    r_winner <= r_winner;
                end
            end else if (w_next_state == ST_IDLE) begin
                r_winner       <= 3'd0;
                r_winner_valid <= 1'b0;
            end else begin
                r_winner       <= r_winner;
                r_winner_valid <= r_winner_valid;
            end
        end
    end

    // Player datapath: spawn in IDLE, tick-driven motion in PLAY, frozen in OVER.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_height <= {NUM_PLAYERS{SPAWN_V}};
            r_grav   <= {NUM_PLAYERS{1'b0}};
            r_alive  <= {NUM_PLAYERS{1'b0}};
            r_pend   <= {NUM_PLAYERS{1'b0}};
            r_tog_q  <= {NUM_PLAYERS{1'b0}};
            r_multi  <= 1'b0;
        end else begin
            r_tog_q <= toggle;
            case (r_state)
                ST_IDLE: begin
                    r_height <= {NUM_PLAYERS{SPAWN_V}};
                    r_grav   <= {NUM_PLAYERS{1'b0}};
                    r_pend   <= {NUM_PLAYERS{1'b0}};
                    if (w_start_ok) begin
                        r_alive <= en;
                        r_multi <= (f_popcount(en) >= 4'd2);
                    end else begin
                        r_alive <= {NUM_PLAYERS{1'b0}};
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        r_height <= w_height_step;
                        r_grav   <= w_grav_step;
                        r_alive  <= w_alive_step;
                        r_pend   <= {NUM_PLAYERS{1'b0}};
                    end else begin
                        r_pend   <= w_pend_eff;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        r_height <= {NUM_PLAYERS{SPAWN_V}};
                        r_grav   <= {NUM_PLAYERS{1'b0}};
                        r_alive  <= {NUM_PLAYERS{1'b0}};
                        r_pend   <= {NUM_PLAYERS{1'b0}};
                    end
                end
                default: begin
                    r_height <= {NUM_PLAYERS{SPAWN_V}};
                    r_grav   <= {NUM_PLAYERS{1'b0}};
                    r_alive  <= {NUM_PLAYERS{1'b0}};
                    r_pend   <= {NUM_PLAYERS{1'b0}};
                end
            endcase
        end
    end

    assign height       = r_height;
    assign grav_dir     = r_grav;
    assign alive        = r_alive;
    assign enable_board = r_enable_board;
    assign game_over    = r_game_over;
    assign winner       = r_winner;
    assign winner_valid = r_winner_valid;

endmodule

// File: tb/tb_gravity_player_array.sv
// Bench for gravity_player_array: two instances (default SPEED=4 and SPEED=6)
// share one stimulus stream; a rule-level model per instance is compared every
// cycle, and directed literal expectations pin the model at key points.
module tb_gravity_player_array;

    localparam int NP = 4;
    localparam int NL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        start;
    logic [3:0]  en;
    logic [3:0]  toggle;
    logic [11:0] lanes;

    logic [35:0] h_a, h_b;
    logic [3:0]  g_a, g_b, a_a, a_b;
    logic        eb_a, eb_b, go_a, go_b, wv_a, wv_b;
    logic [2:0]  w_a, w_b;

    always #5 clk = ~clk;

    gravity_player_array u_dut_a (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .en(en),
        .toggle(toggle), .lanes(lanes), .height(h_a), .grav_dir(g_a),
        .alive(a_a), .enable_board(eb_a), .game_over(go_a), .winner(w_a),
        .winner_valid(wv_a)
    );

    gravity_player_array #(.SPEED(6)) u_dut_b (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .en(en),
        .toggle(toggle), .lanes(lanes), .height(h_b), .grav_dir(g_b),
        .alive(a_b), .enable_board(eb_b), .game_over(go_b), .winner(w_b),
        .winner_valid(wv_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Model state per instance: 0 idle, 1 play, 2 over.
    int m_st    [2];
    int m_h     [2][NP];
    bit m_dir   [2][NP];
    bit m_alv   [2][NP];
    bit m_pnd   [2][NP];
    bit m_multi [2];
    int m_win   [2];
    bit m_wv    [2];
    bit tq      [NP];
    int spd     [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lane_y(input int k);
        return 40 + 160 * k;
    endfunction

    // Apply one frame of the game rules to player p of model u.
    task automatic move(input int u, input int p, input bit pe);
        int h, s, best, y;
        bit grounded, flip, up;
        h = m_h[u][p];
        s = spd[u];
        up = m_dir[u][p];
        grounded = 1'b0;
        for (int k = 0; k < NL; k++)
            if (lanes[p*NL+k] && lane_y(k) == h) grounded = 1'b1;
        flip = grounded && pe;
        if (flip) up = !up;
        best = -1;
        for (int k = 0; k < NL; k++) begin
            y = lane_y(k);
            if (lanes[p*NL+k] && !(flip && y == h)) begin
                if (!up && y <= h && y >= h - s && (best < 0 || y > best)) best = y;
                if (up && y >= h && y <= h + s && (best < 0 || y < best)) best = y;
            end
        end
        m_dir[u][p] = up;
        if (best >= 0) m_h[u][p] = best;
        else if (!up && h - s < 0) m_alv[u][p] = 1'b0;
        else if (up && h + s > 479) m_alv[u][p] = 1'b0;
        else m_h[u][p] = up ? h + s : h - s;
    endtask

    task automatic spawn(input int u);
        for (int p = 0; p < NP; p++) begin
            m_h[u][p] = 200; m_dir[u][p] = 1'b0; m_alv[u][p] = 1'b0; m_pnd[u][p] = 1'b0;
        end
    endtask

    task automatic model_edge(input int u);
        int nal, last;
        bit pe;
        if (reset) begin
            spawn(u);
            m_st[u] = 0; m_multi[u] = 1'b0; m_win[u] = 0; m_wv[u] = 1'b0;
            return;
        end
        case (m_st[u])
            0: begin
                spawn(u);
                if (start && en != 4'd0) begin
                    for (int p = 0; p < NP; p++) m_alv[u][p] = en[p];
                    m_multi[u] = ($countones(en) >= 2);
                    m_st[u] = 1;
                end
            end
            1: begin
                nal = 0; last = 0;
                for (int p = 0; p < NP; p++) if (m_alv[u][p]) begin nal++; last = p; end
                for (int p = 0; p < NP; p++) begin
                    pe = m_pnd[u][p] || (toggle[p] && !tq[p]);
                    if (tick) begin
                        m_pnd[u][p] = 1'b0;
                        if (m_alv[u][p]) move(u, p, pe);
                    end else begin
                        m_pnd[u][p] = pe;
                    end
                end
                if (nal == 0) begin
                    m_st[u] = 2; m_wv[u] = 1'b0;
                end else if (m_multi[u] && nal == 1) begin
                    m_st[u] = 2; m_wv[u] = 1'b1; m_win[u] = last;
                end
            end
            default: begin
                if (start) begin
                    spawn(u);
                    m_st[u] = 0; m_win[u] = 0; m_wv[u] = 1'b0;
                end
            end
        endcase
    endtask

    // Model advances on every active edge from the same inputs the DUTs sample.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) model_edge(u);
        for (int p = 0; p < NP; p++) tq[p] = reset ? 1'b0 : toggle[p];
        chk_on = 1'b1;
    end

    task automatic cmp(input int u, input logic [35:0] h, input logic [3:0] g,
                       input logic [3:0] a, input logic eb, input logic go,
                       input logic [2:0] w, input logic wv);
        logic [35:0] eh;
        logic [3:0]  eg, ea;
        for (int p = 0; p < NP; p++) begin
            eh[p*9 +: 9] = 9'(m_h[u][p]);
            eg[p] = m_dir[u][p];
            ea[p] = m_alv[u][p];
        end
        check($sformatf("model_height_u%0d", u), 64'(h), 64'(eh));
        check($sformatf("model_grav_u%0d", u), 64'(g), 64'(eg));
        check($sformatf("model_alive_u%0d", u), 64'(a), 64'(ea));
        check($sformatf("model_board_u%0d", u), 64'(eb), 64'(m_st[u] == 1));
        check($sformatf("model_over_u%0d", u), 64'(go), 64'(m_st[u] == 2));
        check($sformatf("model_winner_u%0d", u), 64'(w), 64'(m_win[u]));
        check($sformatf("model_wvalid_u%0d", u), 64'(wv), 64'(m_wv[u]));
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp(0, h_a, g_a, a_a, eb_a, go_a, w_a, wv_a);
            cmp(1, h_b, g_b, a_b, eb_b, go_b, w_b, wv_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic gap_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick1();
            step();
        end
    endtask

    task automatic pulse_start(input logic [3:0] e);
        en = e;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        spd[0] = 4;
        spd[1] = 6;
        reset = 1'b1; tick = 1'b0; start = 1'b0; en = 4'd0; toggle = 4'd0; lanes = 12'd0;
        step();
        step();
        check("rst_height", 64'(h_a), 64'({4{9'd200}}));
        check("rst_alive", 64'(a_a), 64'd0);
        check("rst_grav", 64'(g_a), 64'd0);
        check("rst_board", 64'(eb_a), 64'd0);
        check("rst_over", 64'(go_a), 64'd0);
        check("rst_winner", 64'({w_a, wv_a}), 64'd0);
        reset = 1'b0;
        step();

        // start with no player enabled, and ticks in IDLE, are ignored
        pulse_start(4'b0000);
        step();
        check("start_en0_ignored", 64'(eb_a), 64'd0);
        gap_ticks(2);

        // game 1: players 0 and 1
        pulse_start(4'b0011);
        check("start_alive", 64'(a_a), 64'd3);
        check("start_board", 64'(eb_a), 64'd1);
        check("start_alive_b", 64'(a_b), 64'd3);

        gap_ticks(10);
        check("freefall_h_a", 64'(h_a[8:0]), 64'd160);
        check("freefall_alive", 64'(a_a[0]), 64'd1);
        check("freefall_h_b", 64'(h_b[8:0]), 64'd140);

        pulse_start(4'b1111);
        en = 4'b0011;
        step();
        check("start_in_play_ignored", 64'(a_a), 64'd3);

        toggle = 4'b0001;
        step();
        toggle = 4'b0000;
        step();
        gap_ticks(1);
        check("airborne_flip_blocked", 64'(g_a[0]), 64'd0);
        check("airborne_h", 64'(h_a[8:0]), 64'd156);

        lanes = 12'h009;
        gap_ticks(30);
        check("land_h_a", 64'(h_a[8:0]), 64'd40);
        check("land_clamp_h_b", 64'(h_b[8:0]), 64'd40);
        check("land_p1_a", 64'(h_a[17:9]), 64'd40);
        gap_ticks(2);
        check("grounded_stays", 64'(h_a[8:0]), 64'd40);

        toggle = 4'b0001;
        tick = 1'b1;
        step();
        tick = 1'b0;
        toggle = 4'b0000;
        check("grounded_flip_dir", 64'(g_a[0]), 64'd1);
        check("grounded_flip_h_a", 64'(h_a[8:0]), 64'd44);
        check("grounded_flip_h_b", 64'(h_b[8:0]), 64'd46);
        step();

        gap_ticks(72);
        check("top_h_b", 64'(h_b[8:0]), 64'd478);
        tick1();
        check("top_death_alive_b", 64'(a_b), 64'd2);
        check("top_death_hold_b", 64'(h_b[8:0]), 64'd478);
        check("top_death_over_early_b", 64'(go_b), 64'd0);
        step();
        check("top_over_b", 64'(go_b), 64'd1);
        check("top_winner_b", 64'({w_b, wv_b}), 64'({3'd1, 1'b1}));

        gap_ticks(35);
        check("top_h_a", 64'(h_a[8:0]), 64'd476);
        tick1();
        check("top_death_alive_a", 64'(a_a), 64'd2);
        check("top_death_over_early_a", 64'(go_a), 64'd0);
        step();
        check("top_over_a", 64'(go_a), 64'd1);
        check("top_winner_a", 64'({w_a, wv_a}), 64'({3'd1, 1'b1}));
        gap_ticks(2);
        check("over_frozen", 64'(h_a[17:9]), 64'd40);

        // game 2: simultaneous death at the floor
        pulse_start(4'b0000);
        check("return_height", 64'(h_a), 64'({4{9'd200}}));
        check("return_over", 64'(go_a), 64'd0);
        lanes = 12'd0;
        pulse_start(4'b0011);
        gap_ticks(33);
        check("floor_h_b", 64'(h_b[8:0]), 64'd2);
        tick1();
        check("floor_death_b", 64'(a_b), 64'd0);
        check("floor_hold_b", 64'(h_b[8:0]), 64'd2);
        step();
        check("simul_over_b", 64'(go_b), 64'd1);
        check("simul_wvalid_b", 64'(wv_b), 64'd0);
        gap_ticks(16);
        check("floor_h_a", 64'(h_a[8:0]), 64'd0);
        tick1();
        check("floor_death_a", 64'(a_a), 64'd0);
        step();
        check("simul_over_a", 64'(go_a), 64'd1);
        check("simul_wvalid_a", 64'(wv_a), 64'd0);

        // game 3: single player
        pulse_start(4'b0000);
        step();
        pulse_start(4'b0001);
        check("single_alive", 64'(a_a), 64'd1);
        gap_ticks(51);
        check("single_over_a", 64'(go_a), 64'd1);
        check("single_wvalid_a", 64'(wv_a), 64'd0);
        check("single_over_b", 64'(go_b), 64'd1);

        // reset in the middle of a game overrides tick and start
        pulse_start(4'b0000);
        step();
        pulse_start(4'b1111);
        gap_ticks(1);
        reset = 1'b1; tick = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; tick = 1'b0; start = 1'b0;
        check("midreset_board", 64'(eb_a), 64'd0);
        check("midreset_height", 64'(h_a), 64'({4{9'd200}}));
        check("midreset_alive", 64'(a_a), 64'd0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
